// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the I/D memory port arbiter: FSM states, grant values, counter width.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    localparam int CNT_W = 8;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter; master = arbiter view, slave = environment view.
interface mem_port_arbiter_if #(
    parameter int SIZE = 31
);
    logic            i_req;
    logic [SIZE:0]   i_addr;
    logic            i_ack;
    logic [SIZE:0]   i_rdata;
    logic            i_err;

    logic            d_req;
    logic            d_we;
    logic [SIZE:0]   d_addr;
    logic [SIZE:0]   d_wdata;
    logic            d_ack;
    logic [SIZE:0]   d_rdata;
    logic            d_err;

    logic            mem_req;
    logic            mem_we;
    logic [SIZE:0]   mem_addr;
    logic [SIZE:0]   mem_wdata;
    logic            mem_ready;
    logic [SIZE:0]   mem_rdata;

    logic            sel;
    logic            busy;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
        output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
        output mem_req, mem_we, mem_addr, mem_wdata, sel, busy
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
        input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, sel, busy
    );

endinterface

// File: rtl/mem_port_arbiter_mux2.sv
// Generic two-input word mux, combinational.
module mem_port_arbiter_mux2 #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_in0,
    input  logic [W-1:0] i_in1,
    input  logic         i_ctrl,
    output logic [W-1:0] o_out
);
    assign o_out = i_ctrl ? i_in1 : i_in0;
endmodule

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker, combinational: a tie goes to the side opposite i_last.
module mem_port_arbiter_rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic i_req_i,
    input  logic i_req_d,
    input  logic i_last,
    output logic o_gnt,
    output logic o_vld
);
    assign o_vld = i_req_i | i_req_d;
    assign o_gnt = (i_req_i && i_req_d) ? ~i_last : (i_req_d ? GNT_D : GNT_I);
endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for I-fetch and D-access; grant 1 cycle after request, ack 1 cycle after mem_ready.
// Requests are level signals held until ack; they are sampled only in IDLE, with optional timeout to an error ack.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int SIZE    = 31,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.master  bus
);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t           r_state;
    logic             r_last;
    logic             r_sel;
    logic             r_busy;
    logic             r_mem_req;
    logic             r_mem_we;
    logic [SIZE:0]    r_mem_addr;
    logic [SIZE:0]    r_mem_wdata;
    logic             r_i_ack;
    logic             r_d_ack;
    logic             r_i_err;
    logic             r_d_err;
    logic [SIZE:0]    r_i_rdata;
    logic [SIZE:0]    r_d_rdata;
    logic [CNT_W-1:0] r_cnt;

    logic             w_gnt;
    logic             w_vld;
    logic [SIZE:0]    w_addr;
    logic [SIZE:0]    w_wdata;
    logic             w_done;
    logic             w_tmo;
    logic [SIZE:0]    w_rsp_data;

    mem_port_arbiter_rr_pick2 u_pick (
        .i_req_i (bus.i_req),
        .i_req_d (bus.d_req),
        .i_last  (r_last),
        .o_gnt   (w_gnt),
        .o_vld   (w_vld)
    );

    mem_port_arbiter_mux2 #(.W(SIZE + 1)) u_addr_mux (
        .i_in0  (bus.i_addr),
        .i_in1  (bus.d_addr),
        .i_ctrl (w_gnt),
        .o_out  (w_addr)
    );

    mem_port_arbiter_mux2 #(.W(SIZE + 1)) u_wdata_mux (
        .i_in0  ('0),
        .i_in1  (bus.d_wdata),
        .i_ctrl (w_gnt),
        .o_out  (w_wdata)
    );

    // mem_ready beats a timeout landing on the same cycle
    assign w_done     = bus.mem_ready;
    assign w_tmo      = (TIMEOUT != 0) && (r_cnt == TO_LAST) && !bus.mem_ready;
    assign w_rsp_data = (w_done && !r_mem_we) ? bus.mem_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_last      <= GNT_D;
            r_sel       <= GNT_I;
            r_busy      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_i_err     <= 1'b0;
            r_d_err     <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_cnt       <= '0;
        end else begin
            r_i_ack <= 1'b0;
            r_d_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_vld) begin
                        r_sel       <= w_gnt;
                        r_last      <= w_gnt;
                        r_mem_addr  <= w_addr;
                        r_mem_wdata <= w_wdata;
                        r_mem_we    <= w_gnt & bus.d_we;
                        r_mem_req   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_done || w_tmo) begin
                        r_mem_req <= 1'b0;
                        r_state   <= RESP;
                        if (r_sel == GNT_D) begin
                            r_d_rdata <= w_rsp_data;
                            r_d_err   <= w_tmo;
                            r_d_ack   <= 1'b1;
                        end else begin
                            r_i_rdata <= w_rsp_data;
                            r_i_err   <= w_tmo;
                            r_i_ack   <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.sel       = r_sel;
    assign bus.busy      = r_busy;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.i_ack     = r_i_ack;
    assign bus.i_err     = r_i_err;
    assign bus.i_rdata   = r_i_rdata;
    assign bus.d_ack     = r_d_ack;
    assign bus.d_err     = r_d_err;
    assign bus.d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected responses queued at request time, popped on ack.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    typedef struct packed {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    localparam logic [31:0] XK = 32'h5A5A_0F0F;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.SIZE(31)) bus ();

    mem_port_arbiter #(.SIZE(31), .TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    int          mem_wait = 0;
    int          wait_cnt = 0;
    bit          fixed_mode = 1'b0;
    bit          force_ready = 1'b0;
    logic [31:0] fixed_data = '0;

    // memory model: answers mem_wait cycles after mem_req first seen high
    initial begin : responder
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (force_ready) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = 32'hBAD0_BAD0;
            end else if (bus.mem_req) begin
                if (wait_cnt == mem_wait) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = fixed_mode ? fixed_data : (bus.mem_addr ^ XK);
                end else begin
                    bus.mem_ready = 1'b0;
                end
                wait_cnt++;
            end else begin
                bus.mem_ready = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    function automatic exp_t mk(logic port, logic [31:0] rdata, logic err);
        exp_t e;
        e.port = port; e.rdata = rdata; e.err = err;
        return e;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        bus.i_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.i_ack, bus.d_ack, bus.i_err, bus.d_err, bus.busy, bus.sel} !== 8'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b required 00000000",
                {bus.mem_req, bus.mem_we, bus.i_ack, bus.d_ack, bus.i_err, bus.d_err, bus.busy, bus.sel});
        end
        checks++;
        if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem_bus got addr=%h wdata=%h required 0 0", bus.mem_addr, bus.mem_wdata);
        end
        checks++;
        if (bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata got i=%h d=%h required 0 0", bus.i_rdata, bus.d_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got mem_req=%b busy=%b required 0 0", bus.mem_req, bus.busy);
        end
    endtask

    task automatic test_ifetch();
        int mreq = 0, iacks = 0, dacks = 0, ack_cyc = -1;
        exp_t e;
        fixed_mode = 1'b1; fixed_data = 32'h2108_0001; mem_wait = 2;
        bus.i_req = 1'b1; bus.i_addr = 32'h0040_0000;
        sb.push_back(mk(GNT_I, 32'h2108_0001, 1'b0));
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if (bus.mem_req !== 1'b1 || bus.sel !== GNT_I || bus.mem_addr !== 32'h0040_0000 || bus.mem_we !== 1'b0) begin
                    errors++;
                    $display("FAIL ifetch_grant got req=%b sel=%b we=%b addr=%h required 1 0 0 00400000",
                        bus.mem_req, bus.sel, bus.mem_we, bus.mem_addr);
                end
            end
            if (bus.mem_req) mreq++;
            if (bus.d_ack) dacks++;
            if (bus.i_ack) begin
                iacks++; ack_cyc = c; bus.i_req = 1'b0;
                e = sb.pop_front();
                checks++;
                if (bus.i_rdata !== e.rdata || bus.i_err !== e.err) begin
                    errors++;
                    $display("FAIL ifetch_data got rdata=%h err=%b required %h %b", bus.i_rdata, bus.i_err, e.rdata, e.err);
                end
            end
        end
        checks++;
        if (mreq != 3 || iacks != 1 || dacks != 0 || ack_cyc != 4) begin
            errors++;
            $display("FAIL ifetch_timing got mem_req_cycles=%0d i_acks=%0d d_acks=%0d ack_cycle=%0d required 3 1 0 4",
                mreq, iacks, dacks, ack_cyc);
        end
        bus.i_req = 1'b0;
        sb.delete();
    endtask

    task automatic test_dwrite();
        int dacks = 0, iacks = 0, ack_cyc = -1;
        exp_t e;
        fixed_mode = 1'b1; fixed_data = 32'hCAFE_F00D; mem_wait = 0;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h1001_0004; bus.d_wdata = 32'hDEAD_BEEF;
        sb.push_back(mk(GNT_D, 32'h0, 1'b0));
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.sel !== GNT_D ||
                    bus.mem_wdata !== 32'hDEAD_BEEF || bus.mem_addr !== 32'h1001_0004) begin
                    errors++;
                    $display("FAIL dwrite_issue got req=%b we=%b sel=%b addr=%h wdata=%h required 1 1 1 10010004 deadbeef",
                        bus.mem_req, bus.mem_we, bus.sel, bus.mem_addr, bus.mem_wdata);
                end
            end
            if (bus.i_ack) iacks++;
            if (bus.d_ack) begin
                dacks++; ack_cyc = c; bus.d_req = 1'b0;
                e = sb.pop_front();
                checks++;
                if (bus.d_rdata !== e.rdata || bus.d_err !== e.err) begin
                    errors++;
                    $display("FAIL dwrite_data got rdata=%h err=%b required %h %b", bus.d_rdata, bus.d_err, e.rdata, e.err);
                end
            end
        end
        checks++;
        if (dacks != 1 || iacks != 0 || ack_cyc != 2) begin
            errors++;
            $display("FAIL dwrite_timing got d_acks=%0d i_acks=%0d ack_cycle=%0d required 1 0 2", dacks, iacks, ack_cyc);
        end
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        sb.delete();
    endtask

    task automatic test_round_robin();
        int nacks = 0, bad = 0;
        exp_t e;
        do_reset();
        fixed_mode = 1'b0; mem_wait = 1;
        bus.i_addr = 32'h0040_0010; bus.d_addr = 32'h1001_0008; bus.d_we = 1'b0;
        for (int k = 0; k < 4; k++)
            sb.push_back(mk(k[0], (k[0] ? 32'h1001_0008 : 32'h0040_0010) ^ XK, 1'b0));
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        for (int c = 1; c <= 40 && nacks < 4; c++) begin
            @(negedge clk);
            if (bus.mem_req && sb.size() > 0 && bus.sel !== sb[0].port) bad++;
            if (bus.i_ack || bus.d_ack) begin
                nacks++;
                e = sb.pop_front();
                checks++;
                if ((bus.i_ack && bus.d_ack) || bus.d_ack !== e.port ||
                    (e.port ? bus.d_rdata : bus.i_rdata) !== e.rdata) begin
                    errors++;
                    $display("FAIL rr_grant%0d got i_ack=%b d_ack=%b rdata=%h required port=%b rdata=%h",
                        nacks, bus.i_ack, bus.d_ack, e.port ? bus.d_rdata : bus.i_rdata, e.port, e.rdata);
                end
                if (nacks == 4) begin bus.i_req = 1'b0; bus.d_req = 1'b0; end
            end
        end
        checks++;
        if (nacks != 4 || bad != 0) begin
            errors++;
            $display("FAIL rr_sequence got acks=%0d sel_mismatch_cycles=%0d required 4 0", nacks, bad);
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        sb.delete();
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int mreq = 0, ack_cyc = -1, stray = 0;
        exp_t e;
        fixed_mode = 1'b0; mem_wait = 1000;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h1001_0020;
        sb.push_back(mk(GNT_D, 32'h0, 1'b1));
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.mem_req) mreq++;
            if (bus.d_ack) begin
                ack_cyc = c; bus.d_req = 1'b0;
                e = sb.pop_front();
                checks++;
                if (bus.d_rdata !== e.rdata || bus.d_err !== e.err) begin
                    errors++;
                    $display("FAIL timeout_resp got rdata=%h err=%b required %h %b", bus.d_rdata, bus.d_err, e.rdata, e.err);
                end
            end
        end
        checks++;
        if (mreq != 4 || ack_cyc != 5) begin
            errors++;
            $display("FAIL timeout_timing got mem_req_cycles=%0d ack_cycle=%0d required 4 5", mreq, ack_cyc);
        end
        force_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.i_ack || bus.d_ack || bus.busy || bus.mem_req) stray++;
        end
        force_ready = 1'b0;
        checks++;
        if (stray != 0 || bus.d_rdata !== 32'h0 || bus.d_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_late_ready got stray=%0d d_rdata=%h d_err=%b required 0 0 1", stray, bus.d_rdata, bus.d_err);
        end
        sb.delete();
    endtask

    task automatic test_ready_at_timeout();
        int ack_cyc = -1, mreq = 0;
        exp_t e;
        fixed_mode = 1'b0; mem_wait = 3;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h1001_0030;
        sb.push_back(mk(GNT_D, 32'h1001_0030 ^ XK, 1'b0));
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.mem_req) mreq++;
            if (bus.d_ack) begin
                ack_cyc = c; bus.d_req = 1'b0;
                e = sb.pop_front();
                checks++;
                if (bus.d_rdata !== e.rdata || bus.d_err !== e.err) begin
                    errors++;
                    $display("FAIL ready_vs_timeout got rdata=%h err=%b required %h %b", bus.d_rdata, bus.d_err, e.rdata, e.err);
                end
            end
        end
        checks++;
        if (mreq != 4 || ack_cyc != 5) begin
            errors++;
            $display("FAIL ready_vs_timeout_timing got mem_req_cycles=%0d ack_cycle=%0d required 4 5", mreq, ack_cyc);
        end
        sb.delete();
    endtask

    task automatic test_reset_mid();
        int stray = 0, got = 0;
        exp_t e;
        fixed_mode = 1'b0; mem_wait = 1000;
        bus.i_req = 1'b1; bus.i_addr = 32'h0040_0020;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre got mem_req=%b busy=%b required 1 1", bus.mem_req, bus.busy);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0 || bus.i_ack !== 1'b0 || bus.d_ack !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async got mem_req=%b busy=%b i_ack=%b d_ack=%b required 0 0 0 0",
                bus.mem_req, bus.busy, bus.i_ack, bus.d_ack);
        end
        bus.i_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        force_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 1) force_ready = 1'b0;
            if (bus.i_ack || bus.d_ack || bus.mem_req) stray++;
        end
        force_ready = 1'b0;
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL rstmid_no_ack got stray_cycles=%0d required 0", stray);
        end
        mem_wait = 0;
        bus.i_addr = 32'h0040_0030; bus.d_addr = 32'h1001_0040; bus.d_we = 1'b0;
        sb.push_back(mk(GNT_I, 32'h0040_0030 ^ XK, 1'b0));
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        for (int c = 1; c <= 10 && got == 0; c++) begin
            @(negedge clk);
            if (bus.i_ack || bus.d_ack) begin
                got = 1;
                bus.i_req = 1'b0; bus.d_req = 1'b0;
                e = sb.pop_front();
                checks++;
                if (bus.i_ack !== 1'b1 || bus.d_ack !== 1'b0 || bus.i_rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL rstmid_tie got i_ack=%b d_ack=%b i_rdata=%h required 1 0 %h",
                        bus.i_ack, bus.d_ack, bus.i_rdata, e.rdata);
                end
            end
        end
        checks++;
        if (got == 0) begin
            errors++;
            $display("FAIL rstmid_tie_timeout got no ack required one ack");
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_ifetch();
        test_dwrite();
        test_round_robin();
        test_timeout();
        test_ready_at_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got simulation still running required finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between the instruction-fetch (I) and data-access (D) requesters of the MIPS pipeline.
- Decides which requester owns the port and drives the select line of the address/write-data muxes feeding memory.
- Sequences each memory transaction: issue, wait for ready, return data with an ack pulse.
- Round-robin on ties; an optional timeout returns an error instead of hanging the pipeline.

Parameters:
- SIZE, 31, MSB index of address and data buses (buses are [SIZE:0]).
- TIMEOUT, 64, max cycles mem_req waits for mem_ready; 0 disables timeout; legal range 0..255.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_req  input  1  instruction fetch request; level, held until i_ack.
- i_addr  input  SIZE+1  fetch address.
- i_ack  output  1  one-cycle pulse: i_rdata/i_err valid.
- i_rdata  output  SIZE+1  fetched word (registered).
- i_err  output  1  valid with i_ack; 1 = timeout.
- d_req  input  1  data request; level, held until d_ack.
- d_we  input  1  1 = write, 0 = read.
- d_addr  input  SIZE+1  data address.
- d_wdata  input  SIZE+1  write data.
- d_ack  output  1  one-cycle pulse: d_rdata/d_err valid.
- d_rdata  output  SIZE+1  read word (registered; 0 after a write).
- d_err  output  1  valid with d_ack; 1 = timeout.
- mem_req  output  1  memory request; held until mem_ready or timeout.
- mem_we  output  1  write enable (registered).
- mem_addr  output  SIZE+1  registered address.
- mem_wdata  output  SIZE+1  registered write data.
- mem_ready  input  1  memory done; mem_rdata valid the same cycle.
- mem_rdata  input  SIZE+1  memory read data.
- sel  output  1  current owner / mux ctrl: 0 = I, 1 = D.
- busy  output  1  1 when state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, last_grant=D.
  - mem_req, mem_we, i_ack, d_ack, i_err, d_err, busy = 0.
  - sel=0; mem_addr, mem_wdata, i_rdata, d_rdata = 0.
  - Reset mid-transaction abandons it: no ack is issued, and any late mem_ready is ignored.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - Requests are sampled only in this state.
  - If no request, remain in IDLE.
  - If exactly one requester is active, grant it.
  - If both are active, grant the one opposite last_grant; the first tie after reset goes to I.
  - On grant (next edge):
    - sel=winner, last_grant=winner.
    - Capture mem_addr/mem_wdata via the sel-controlled muxes.
    - mem_we = d_we if D wins, else 0.
    - mem_req=1, timeout counter=0, go to ISSUE.
  - Grant latency: request in IDLE → mem_req high on the next cycle.
- ISSUE:
  - mem_req, sel, mem_addr, mem_we, mem_wdata are held stable.
  - The counter increments each cycle without mem_ready.
  - If mem_ready=1: capture mem_rdata into the winner's rdata (D write → d_rdata=0), err=0, mem_req=0, go to RESP.
  - Else if TIMEOUT!=0 and the counter reaches TIMEOUT-1: winner's rdata=0, err=1, mem_req=0, go to RESP.
  - mem_ready and timeout in the same cycle: mem_ready wins (err=0).
- RESP:
  - Winner's ack=1 for exactly this cycle; the other requester's ack stays 0.
  - Requests are ignored; next state is IDLE.
  - A requester still asserting req in the following IDLE cycle is treated as a new request.
- Ack-to-next-grant: minimum transaction = 3 cycles (IDLE→ISSUE→RESP) with 0-wait memory.
- mem_ready outside ISSUE is ignored.
- sel holds its value in IDLE/RESP; it changes only on grant.
- rdata registers hold their value until the next completion for that port.
- Address/data widths pass through unchanged; no alignment checks.

Decomposition:
- Shared include (e.g. mips_defs.vh):
  - State encodings IDLE=2'd0, ISSUE=2'd1, RESP=2'd2.
  - Grant encodings GNT_I=1'b0, GNT_D=1'b1.
- Sub-modules:
  - Reuse the existing parameterized mux for the addr and wdata selection (ctrl=sel).
  - One natural new sub-module: rr_pick2 (combinational 2-way round-robin picker: req_i, req_d, last → gnt).

Test Plan:
- Reset then i_req=1, i_addr=0x0040_0000, memory ready 2 cycles after mem_req, mem_rdata=0x2108_0001 → sel=0, mem_req high 1 cycle after req for 3 cycles, i_ack single pulse, i_rdata=0x2108_0001, i_err=0, d_ack never.
- d_req=1, d_we=1, d_addr=0x1001_0004, d_wdata=0xDEAD_BEEF, 0-wait memory → mem_we=1, mem_wdata=0xDEAD_BEEF, d_ack 2 cycles after grant edge, d_rdata=0.
- i_req and d_req held high continuously, both re-asserted after each ack → grants I, D, I, D (first tie after reset goes to I); no ack ever goes to the non-granted port.
- TIMEOUT=4, mem_ready held 0 on a D read → mem_req high exactly 4 cycles, then d_ack=1 with d_err=1, d_rdata=0; a late mem_ready is ignored.
- rst_n pulsed low while in ISSUE → mem_req, busy, and acks drop immediately (asynchronously); no ack after release; the next tie is granted to I.
- mem_ready asserted on the same cycle the counter hits TIMEOUT-1 → err=0, rdata=mem_rdata.
